// File: rtl/ioport_defs.sv
// Shared definitions for the echo FIFO I/O port: address offsets,
// status bit positions, port decode type and level saturation.
package ioport_defs;

    localparam logic [7:0] OFS_WR = 8'd0;
    localparam logic [7:0] OFS_RD = 8'd1;
    localparam logic [7:0] OFS_ST = 8'd2;

    localparam int ST_OVF = 7;
    localparam int ST_UDF = 6;

    typedef enum logic [1:0] {
        P_NONE,
        P_WR,
        P_RD,
        P_ST
    } port_e;

    function automatic logic [5:0] sat6(input int unsigned lvl);
        return (lvl > 63) ? 6'd63 : lvl[5:0];
    endfunction

endpackage

// File: rtl/echo_fifo_port_if.sv
// Bus side (address/select/byte strobes) and stream side of the
// echo FIFO port, bundled for the master and the port.
interface echo_fifo_port_if #(
    parameter int WIDTH = 2
);
    logic [7:0]         ADDR;
    logic               SEL;
    logic [7:0]         RXD;
    logic               RXE;
    logic [7:0]         TXD;
    logic [8*WIDTH-1:0] OUT_DATA;
    logic               OUT_VALID;
    logic               OUT_READY;

    modport master (
        output ADDR, SEL, RXD, RXE, OUT_READY,
        input  TXD, OUT_DATA, OUT_VALID
    );

    modport slave (
        input  ADDR, SEL, RXD, RXE, OUT_READY,
        output TXD, OUT_DATA, OUT_VALID
    );
endinterface

// File: rtl/sync_fifo.sv
// Word FIFO with level count; exposes the head and the entry behind it
// so the owner can register outputs from next-cycle state.
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [DW-1:0]          i_data,
    output logic [DW-1:0]          o_head,
    output logic [DW-1:0]          o_head2,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW-1:0] w_rp1;
    logic [LW-1:0] r_lvl;

    assign w_rp1 = r_rp + AW'(1);

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
        end else begin
            r_wp  <= r_wp + AW'(i_push);
            r_rp  <= r_rp + AW'(i_pop);
            r_lvl <= r_lvl + LW'(i_push) - LW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_head2 = r_mem[w_rp1];
    assign o_full  = (r_lvl == LW'(DEPTH));
    assign o_empty = (r_lvl == '0);
    assign o_level = r_lvl;

endmodule

// File: rtl/echo_fifo_port.sv
// Echo FIFO port: bytes written at ADDRESS are packed into words and
// returned by byte readback (MODE 0) or on the stream port (MODE 1).
module echo_fifo_port
    import ioport_defs::*;
#(
    parameter logic [7:0] ADDRESS = 8'h00,
    parameter int         WIDTH   = 2,
    parameter int         DEPTH   = 16,
    parameter int         MODE    = 0
) (
    input logic             CLK,
    input logic             nRST,
    echo_fifo_port_if.slave bus
);
    localparam int DW = 8 * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    localparam logic [7:0] A_WR = ADDRESS + OFS_WR;
    localparam logic [7:0] A_RD = ADDRESS + OFS_RD;
    localparam logic [7:0] A_ST = ADDRESS + OFS_ST;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    port_e         w_port, r_port;
    logic          w_end_wr, w_end_rd;
    logic          w_rx_wr, w_rx_rd, w_rx_st;
    logic          w_push, w_pop, w_push_ok, w_pop_ok;
    logic          w_full, w_empty;
    logic [LW-1:0] w_lvl, w_lvl_nxt;
    logic [DW-1:0] w_head, w_head2, w_word, w_head_nxt;
    logic [DW-1:0] r_asm, w_asm_nxt, r_out;
    logic [IW-1:0] r_wi, w_wi_nxt, r_ri, w_ri_nxt;
    logic          r_ovf, r_udf, w_ovf_nxt, w_udf_nxt, r_valid;
    logic [7:0]    r_txd, w_txd, w_byte;

    // Reset asserts at once but releases two CLK edges later
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_rst_sync <= 2'b00;
        else       r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_port = P_NONE;
        unique case (1'b1)
            bus.SEL && (bus.ADDR == A_WR): w_port = P_WR;
            bus.SEL && (bus.ADDR == A_RD): w_port = P_RD;
            bus.SEL && (bus.ADDR == A_ST): w_port = P_ST;
            default:                       w_port = P_NONE;
        endcase
    end

    // Deselect and address change both close the old transaction
    assign w_end_wr = (r_port == P_WR) && (w_port != P_WR);
    assign w_end_rd = (r_port == P_RD) && (w_port != P_RD);
    assign w_rx_wr  = bus.RXE && (w_port == P_WR);
    assign w_rx_rd  = bus.RXE && (w_port == P_RD);
    assign w_rx_st  = bus.RXE && (w_port == P_ST);

    assign w_word = w_rx_wr ? (r_asm | (DW'(bus.RXD) << (8 * (WIDTH - 1))))
                            : r_asm;
    assign w_push = (w_rx_wr && (r_wi == LAST)) || (w_end_wr && (r_wi != '0));
    assign w_pop  = (MODE == 0)
                  ? ((w_rx_rd && (r_ri == LAST)) || (w_end_rd && (r_ri != '0)))
                  : (bus.OUT_READY && !w_empty);
    assign w_pop_ok  = w_pop && !w_empty;
    assign w_push_ok = w_push && (!w_full || w_pop_ok);
    assign w_lvl_nxt = w_lvl + LW'(w_push_ok) - LW'(w_pop_ok);

    always_comb begin
        w_wi_nxt  = r_wi;
        w_asm_nxt = r_asm;
        if (w_end_wr || (w_rx_wr && (r_wi == LAST))) begin
            w_wi_nxt  = '0;
            w_asm_nxt = '0;
        end else if (w_rx_wr) begin
            w_asm_nxt = r_asm | (DW'(bus.RXD) << {r_wi, 3'b000});
            w_wi_nxt  = r_wi + IW'(1);
        end
    end

    always_comb begin
        w_ri_nxt = r_ri;
        if (MODE == 0) begin
            if (w_end_rd || (w_rx_rd && !w_empty && (r_ri == LAST)))
                w_ri_nxt = '0;
            else if (w_rx_rd && !w_empty)
                w_ri_nxt = r_ri + IW'(1);
        end
    end

    always_comb begin
        w_ovf_nxt = r_ovf && !w_rx_st;
        w_udf_nxt = r_udf && !w_rx_st;
        if (w_push && !w_push_ok) w_ovf_nxt = 1'b1;
        if ((MODE == 0) && w_rx_rd && w_empty) w_udf_nxt = 1'b1;
    end

    // Head word as it will be after this edge, for registered outputs
    always_comb begin
        if (w_lvl_nxt == '0)
            w_head_nxt = '0;
        else if (w_pop_ok)
            w_head_nxt = (w_lvl > LW'(1)) ? w_head2 : w_word;
        else
            w_head_nxt = w_empty ? w_word : w_head;
    end

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < WIDTH; i++)
            if (w_ri_nxt == IW'(i)) w_byte = w_head_nxt[8*i +: 8];
    end

    always_comb begin
        w_txd = 8'h00;
        unique case (1'b1)
            w_port == P_ST: begin
                w_txd[ST_OVF] = w_ovf_nxt;
                w_txd[ST_UDF] = w_udf_nxt;
                w_txd[5:0]    = sat6(32'(w_lvl_nxt));
            end
            (w_port == P_RD) && (MODE == 0): w_txd = w_byte;
            default: w_txd = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_port  <= P_NONE;
            r_wi    <= '0;
            r_ri    <= '0;
            r_asm   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_txd   <= 8'h00;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_port  <= w_port;
            r_wi    <= w_wi_nxt;
            r_ri    <= w_ri_nxt;
            r_asm   <= w_asm_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
            r_txd   <= w_txd;
            r_valid <= (MODE == 1) && (w_lvl_nxt != '0);
            r_out   <= (MODE == 1) ? w_head_nxt : '0;
        end
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (w_rst_n),
        .i_push  (w_push_ok),
        .i_pop   (w_pop_ok),
        .i_data  (w_word),
        .o_head  (w_head),
        .o_head2 (w_head2),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_lvl)
    );

    assign bus.TXD       = r_txd;
    assign bus.OUT_VALID = r_valid;
    assign bus.OUT_DATA  = r_out;

endmodule

// File: tb/tb_echo_fifo_port.sv
// Three port instances on one wired-OR byte bus: A (W2 D16 SPI),
// B (W1 D4 SPI), C (W4 D4 stream); vectors scored through a queue.
module tb_echo_fifo_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] t_addr = 8'h00;
    logic [7:0] t_rxd = 8'h00;
    logic       t_sel = 1'b0;
    logic       t_rxe = 1'b0;
    logic       t_rdy = 1'b0;

    always #5 clk = ~clk;

    echo_fifo_port_if #(.WIDTH(2)) ia ();
    echo_fifo_port_if #(.WIDTH(1)) ib ();
    echo_fifo_port_if #(.WIDTH(4)) ic ();

    assign ia.ADDR = t_addr;  assign ib.ADDR = t_addr;  assign ic.ADDR = t_addr;
    assign ia.SEL  = t_sel;   assign ib.SEL  = t_sel;   assign ic.SEL  = t_sel;
    assign ia.RXD  = t_rxd;   assign ib.RXD  = t_rxd;   assign ic.RXD  = t_rxd;
    assign ia.RXE  = t_rxe;   assign ib.RXE  = t_rxe;   assign ic.RXE  = t_rxe;
    assign ia.OUT_READY = t_rdy;
    assign ib.OUT_READY = t_rdy;
    assign ic.OUT_READY = t_rdy;

    echo_fifo_port #(.ADDRESS(8'h10), .WIDTH(2), .DEPTH(16), .MODE(0))
        u_a (.CLK(clk), .nRST(rst_n), .bus(ia.slave));
    echo_fifo_port #(.ADDRESS(8'h20), .WIDTH(1), .DEPTH(4), .MODE(0))
        u_b (.CLK(clk), .nRST(rst_n), .bus(ib.slave));
    echo_fifo_port #(.ADDRESS(8'h30), .WIDTH(4), .DEPTH(4), .MODE(1))
        u_c (.CLK(clk), .nRST(rst_n), .bus(ic.slave));

    wire [7:0] txd = ia.TXD | ib.TXD | ic.TXD;

    typedef enum {OP_SEL, OP_DSL, OP_WR, OP_XF, OP_CK, OP_OUT, OP_XR, OP_POP} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  a;
        logic [32:0] e;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(op_e op, logic [7:0] a, logic [32:0] e);
        vec_t v;
        v.op = op;
        v.a  = a;
        v.e  = e;
        return v;
    endfunction

    function automatic void sel_(logic [7:0] a);   tbl.push_back(mk(OP_SEL, a, '0)); endfunction
    function automatic void dsl_();                tbl.push_back(mk(OP_DSL, 8'h00, '0)); endfunction
    function automatic void wr_(logic [7:0] d);    tbl.push_back(mk(OP_WR, d, '0)); endfunction
    function automatic void xr_(logic [7:0] d);    tbl.push_back(mk(OP_XR, d, '0)); endfunction
    function automatic void pop_();                tbl.push_back(mk(OP_POP, 8'h00, '0)); endfunction
    function automatic void ck_(logic [7:0] e);    tbl.push_back(mk(OP_CK, 8'h00, {25'd0, e})); endfunction
    function automatic void out_(logic [32:0] e);  tbl.push_back(mk(OP_OUT, 8'h00, e)); endfunction
    function automatic void xf_(logic [7:0] e);    tbl.push_back(mk(OP_XF, 8'h00, {25'd0, e})); endfunction

    task automatic cmp(int idx, string nm, logic [32:0] act);
        logic [32:0] exp;
        exp = sb.pop_front();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL step %0d %s: got %h, want %h", idx, nm, act, exp);
        end
    endtask

    task automatic strobe(logic [7:0] d, logic rdy);
        t_rxd = d;
        t_rxe = 1'b1;
        t_rdy = rdy;
        @(negedge clk);
        t_rxe = 1'b0;
        t_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply(int idx, vec_t v);
        case (v.op)
            OP_SEL: begin t_sel = 1'b1; t_addr = v.a; @(negedge clk); end
            OP_DSL: begin t_sel = 1'b0; @(negedge clk); end
            OP_WR:  strobe(v.a, 1'b0);
            OP_XR:  strobe(v.a, 1'b1);
            OP_XF: begin
                sb.push_back(v.e);
                cmp(idx, "txd_xfer", {25'd0, txd});
                strobe(v.a, 1'b0);
            end
            OP_CK: begin
                sb.push_back(v.e);
                cmp(idx, "txd", {25'd0, txd});
            end
            OP_OUT: begin
                sb.push_back(v.e);
                cmp(idx, "out_valid_data", {ic.OUT_VALID, ic.OUT_DATA});
            end
            OP_POP: begin
                t_rdy = 1'b1;
                @(negedge clk);
                t_rdy = 1'b0;
                @(negedge clk);
            end
            default: ;
        endcase
    endtask

    task automatic hs(int idx, op_e op, logic [7:0] a, logic [32:0] e);
        apply(idx, mk(op, a, e));
    endtask

    initial begin
        // status of every port right after reset
        sel_(8'h12); ck_(8'h00); dsl_();
        sel_(8'h22); ck_(8'h00); dsl_();
        sel_(8'h32); ck_(8'h00); dsl_();
        // A: two full words back in order
        sel_(8'h10); wr_(8'h01); wr_(8'h02); wr_(8'h03); wr_(8'h04); dsl_();
        sel_(8'h11); xf_(8'h01); xf_(8'h02); xf_(8'h03); xf_(8'h04); dsl_();
        sel_(8'h12); ck_(8'h00); dsl_();
        // A: partial word padded on deselect
        sel_(8'h10); wr_(8'hAA); wr_(8'hBB); wr_(8'hCC); dsl_();
        sel_(8'h11); xf_(8'hAA); xf_(8'hBB); xf_(8'hCC); xf_(8'h00); dsl_();
        sel_(8'h12); ck_(8'h00); dsl_();
        // A: empty read sets UDF, status strobe clears it
        sel_(8'h11); ck_(8'h00); xf_(8'h00); dsl_();
        sel_(8'h12); ck_(8'h40); xf_(8'h40); ck_(8'h00); dsl_();
        // unclaimed address ignores strobes
        sel_(8'h13); ck_(8'h00); wr_(8'h77); dsl_();
        sel_(8'h12); ck_(8'h00); dsl_();
        // A: address change closes the write, then the read
        sel_(8'h10); wr_(8'h5A);
        sel_(8'h11); xf_(8'h5A); xf_(8'h00);
        sel_(8'h12); ck_(8'h00); dsl_();
        // A: deselect mid-word discards the remainder
        sel_(8'h10); wr_(8'h01); wr_(8'h02); wr_(8'h03); wr_(8'h04); dsl_();
        sel_(8'h11); xf_(8'h01); dsl_();
        sel_(8'h12); ck_(8'h01); dsl_();
        sel_(8'h11); xf_(8'h03); xf_(8'h04); dsl_();
        sel_(8'h12); ck_(8'h00); dsl_();
        // B: overflow on the fifth byte of a 4-deep FIFO
        sel_(8'h20); wr_(8'h10); wr_(8'h11); wr_(8'h12); wr_(8'h13); wr_(8'h14); dsl_();
        sel_(8'h22); ck_(8'h84); xf_(8'h84); ck_(8'h04); dsl_();
        sel_(8'h21); xf_(8'h10); xf_(8'h11); xf_(8'h12); xf_(8'h13); dsl_();
        sel_(8'h22); ck_(8'h00); dsl_();
        // C: stream head word
        out_(33'h0_0000_0000);
        sel_(8'h30); wr_(8'h11); wr_(8'h22); wr_(8'h33); wr_(8'h44);
        out_({1'b1, 32'h44332211});
        sel_(8'h32); ck_(8'h01);
        sel_(8'h30); wr_(8'h55); wr_(8'h66); wr_(8'h77); wr_(8'h88);
        wr_(8'h99); wr_(8'hAA); wr_(8'hBB); wr_(8'hCC);
        wr_(8'hDD); wr_(8'hEE); wr_(8'hFF); wr_(8'h01);
        out_({1'b1, 32'h44332211});
        // C: full, push and pop in the same cycle
        wr_(8'h02); wr_(8'h03); wr_(8'h04); xr_(8'h05); dsl_();
        sel_(8'h32); ck_(8'h04); dsl_();
        out_({1'b1, 32'h88776655});
        // C: read address is inert in stream mode
        sel_(8'h31); ck_(8'h00); xf_(8'h00); dsl_();
        sel_(8'h32); ck_(8'h04); dsl_();
        // C: push into a full FIFO with no consumer
        sel_(8'h30); wr_(8'h09); wr_(8'h09); wr_(8'h09); wr_(8'h09); dsl_();
        sel_(8'h32); ck_(8'h84); xf_(8'h84); ck_(8'h04); dsl_();
        // C: drain
        pop_(); out_({1'b1, 32'hCCBBAA99});
        pop_(); out_({1'b1, 32'h01FFEEDD});
        pop_(); out_({1'b1, 32'h05040302});
        pop_(); out_(33'h0_0000_0000);
        sel_(8'h32); ck_(8'h00); dsl_();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back(33'd0);
        cmp(-1, "txd_after_reset", {25'd0, txd});
        sb.push_back(33'd0);
        cmp(-1, "out_after_reset", {ic.OUT_VALID, ic.OUT_DATA});

        foreach (tbl[i]) apply(i, tbl[i]);

        // reset in the middle of a write must not leave a partial word
        hs(900, OP_SEL, 8'h30, '0);
        hs(901, OP_WR, 8'h01, '0); hs(902, OP_WR, 8'h02, '0);
        hs(903, OP_WR, 8'h03, '0); hs(904, OP_WR, 8'h04, '0);
        hs(905, OP_DSL, 8'h00, '0);
        hs(906, OP_OUT, 8'h00, {1'b1, 32'h04030201});
        hs(907, OP_SEL, 8'h10, '0);
        hs(908, OP_WR, 8'h66, '0);
        rst_n = 1'b0;
        #1;
        sb.push_back(33'd0);
        cmp(909, "out_in_reset", {ic.OUT_VALID, ic.OUT_DATA});
        sb.push_back(33'd0);
        cmp(910, "txd_in_reset", {25'd0, txd});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        hs(911, OP_OUT, 8'h00, 33'd0);
        hs(912, OP_CK, 8'h00, 33'd0);
        hs(913, OP_DSL, 8'h00, '0);
        hs(914, OP_SEL, 8'h12, '0);
        hs(915, OP_CK, 8'h00, 33'd0);
        hs(916, OP_SEL, 8'h32, '0);
        hs(917, OP_CK, 8'h00, 33'd0);
        hs(918, OP_SEL, 8'h11, '0);
        hs(919, OP_CK, 8'h00, 33'd0);
        hs(920, OP_DSL, 8'h00, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
